// File: rtl/apb_req_arbiter.sv
// Round-robin APB master sharing one slave port among NREQ requesters.
// Sequences IDLE/SETUP/ACCESS and completes with an error after TIMEOUT ACCESS cycles.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_done,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic                     busy,
  output logic                     p_sel,
  output logic                     p_en,
  output logic                     p_write,
  output logic [AWIDTH-1:0]        addr,
  output logic [DWIDTH-1:0]        wdata,
  input  logic [DWIDTH-1:0]        rdata,
  input  logic                     p_ready
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  ptr_next;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] elig;
  logic            found;
  logic            finish;
  int unsigned     j;

  // A requester whose done pulse is visible this cycle is masked so it is not reissued.
  always_comb begin
    elig  = req & ~req_done;
    pick  = ptr;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = IDW'(j);
      end
    end
  end

  always_comb begin
    ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    finish   = p_ready || (cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      p_sel     <= 1'b0;
      p_en      <= 1'b0;
      p_write   <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
    end else begin
      req_done <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            win     <= pick;
            addr    <= req_addr[32'(pick)*AWIDTH +: AWIDTH];
            wdata   <= req_wdata[32'(pick)*DWIDTH +: DWIDTH];
            p_write <= req_write[pick];
            p_sel   <= 1'b1;
            busy    <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          p_en  <= 1'b1;
          cnt   <= '0;
          state <= S_ACCESS;
        end
        S_ACCESS: begin
          // A ready arriving on the final allowed cycle still counts as success.
          if (finish) begin
            req_done[win] <= 1'b1;
            rsp_id        <= win;
            rsp_err       <= ~p_ready;
            rsp_rdata     <= (p_ready && !p_write) ? rdata : '0;
            p_sel         <= 1'b0;
            p_en          <= 1'b0;
            busy          <= 1'b0;
            ptr           <= ptr_next;
            state         <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter against a registered-ready APB RAM model.
module tb_apb_req_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int TO   = 16;
  localparam int IDW  = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ-1:0]      req_write = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_wdata = '0;
  logic [NREQ-1:0]      req_done;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic [IDW-1:0]       rsp_id;
  logic                 busy, p_sel, p_en, p_write;
  logic [AW-1:0]        addr;
  logic [DW-1:0]        wdata;
  logic [DW-1:0]        rdata;
  logic                 p_ready;
  logic                 ready_en = 1'b1;
  logic [DW-1:0]        mem [256];

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int viol = 0;
  logic prev_setup = 1'b0;
  logic prev_en = 1'b0;

  apb_req_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_id(rsp_id), .busy(busy), .p_sel(p_sel), .p_en(p_en), .p_write(p_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .p_ready(p_ready)
  );

  always #5 clk = ~clk;

  // Slave RAM with registered ready; ready lingers one cycle after p_en falls.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_ready <= 1'b0;
      rdata   <= '0;
    end else begin
      rdata   <= mem[addr];
      p_ready <= ready_en & p_sel & p_en;
      if (p_sel && p_en && p_write) mem[addr] <= wdata;
    end
  end

  always @(negedge clk) begin
    if (p_sel && p_en) en_cnt <= en_cnt + 1;
    if ((p_en && !p_sel) || (p_en && !prev_en && !prev_setup)) viol <= viol + 1;
    prev_setup <= p_sel & ~p_en;
    prev_en    <= p_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
    req[i]                  = 1'b1;
  endtask

  task automatic wait_done(output logic [NREQ-1:0] d, output int n);
    n = 0;
    d = '0;
    while (n < 64) begin
      @(posedge clk);
      #1;
      n++;
      if (req_done != '0) begin
        d = req_done;
        return;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [NREQ+DW+1+IDW+4+AW+DW-1:0] outs;
    tick();
    tick();
    outs = {req_done, rsp_rdata, rsp_err, rsp_id, busy, p_sel, p_en, p_write, addr, wdata};
    tests++;
    if (outs !== '0) begin fails++; $display("FAIL reset_outputs got=%0h exp=0", outs); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [NREQ-1:0] d;
    int n, c0;
    c0 = en_cnt;
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    wait_done(d, n);
    tests++; if (d !== 4'b0001) begin fails++; $display("FAIL wr_done got=%b exp=0001", d); end
    tests++; if (n !== 4) begin fails++; $display("FAIL wr_latency got=%0d exp=4", n); end
    tests++; if (en_cnt - c0 !== 2) begin fails++; $display("FAIL wr_access_cycles got=%0d exp=2", en_cnt - c0); end
    tests++; if ({rsp_err, rsp_id, rsp_rdata} !== '0) begin fails++; $display("FAIL wr_rsp got=%0h exp=0", {rsp_err, rsp_id, rsp_rdata}); end
    tests++; if (addr !== 8'h10 || p_write !== 1'b1 || wdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL wr_payload_hold got=%0h/%0b/%0h exp=10/1/deadbeef", addr, p_write, wdata); end
    req[0] = 1'b0;
    tick();
    set_req(0, 1'b0, 8'h10, 32'h0);
    wait_done(d, n);
    req[0] = 1'b0;
    tests++; if (d !== 4'b0001 || n !== 4) begin fails++; $display("FAIL rd_done got=%b/%0d exp=0001/4", d, n); end
    tests++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
      fails++; $display("FAIL rd_data got=%0h/%0b exp=deadbeef/0", rsp_rdata, rsp_err); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] d;
    int n;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(8'h20 + i), DW'(32'hC0DE0000 + i));
    for (int k = 0; k < NREQ; k++) begin
      wait_done(d, n);
      req[k] = 1'b0;
      tests++; if (d !== NREQ'(1) << k || n !== 4 || rsp_id !== IDW'(k)) begin
        fails++; $display("FAIL rr_write_order k=%0d got=%b/%0d/%0d exp=%b/4/%0d", k, d, n, rsp_id, NREQ'(1) << k, k); end
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(8'h20 + i), '0);
    for (int k = 0; k < NREQ; k++) begin
      wait_done(d, n);
      req[k] = 1'b0;
      tests++; if (d !== NREQ'(1) << k || rsp_rdata !== DW'(32'hC0DE0000 + k)) begin
        fails++; $display("FAIL rr_readback k=%0d got=%b/%0h exp=%b/%0h", k, d, rsp_rdata, NREQ'(1) << k, 32'hC0DE0000 + k); end
    end
    tick();
  endtask

  task automatic test_hold_masking();
    logic [NREQ-1:0] d;
    int n;
    set_req(1, 1'b1, 8'h40, 32'h11110001);
    tick();
    tests++; if (p_sel !== 1'b1 || busy !== 1'b1 || p_en !== 1'b0) begin
      fails++; $display("FAIL hold_setup got=%b%b%b exp=110", p_sel, busy, p_en); end
    set_req(2, 1'b0, 8'h40, '0);
    wait_done(d, n);
    tests++; if (d !== 4'b0010) begin fails++; $display("FAIL hold_first got=%b exp=0010", d); end
    wait_done(d, n);
    req[2] = 1'b0;
    tests++; if (d !== 4'b0100 || n !== 4 || rsp_rdata !== 32'h11110001) begin
      fails++; $display("FAIL hold_second got=%b/%0d/%0h exp=0100/4/11110001", d, n, rsp_rdata); end
    wait_done(d, n);
    tests++; if (d !== 4'b0010 || n !== 4) begin fails++; $display("FAIL hold_third got=%b/%0d exp=0010/4", d, n); end
    wait_done(d, n);
    req[1] = 1'b0;
    tests++; if (d !== 4'b0010 || n !== 5) begin fails++; $display("FAIL hold_masked_gap got=%b/%0d exp=0010/5", d, n); end
    tick();
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] d;
    int n, c0;
    ready_en = 1'b0;
    c0 = en_cnt;
    set_req(3, 1'b0, 8'h21, '0);
    wait_done(d, n);
    req[3] = 1'b0;
    tests++; if (d !== 4'b1000 || n !== TO + 2) begin fails++; $display("FAIL to_done got=%b/%0d exp=1000/%0d", d, n, TO + 2); end
    tests++; if (en_cnt - c0 !== TO) begin fails++; $display("FAIL to_access_cycles got=%0d exp=%0d", en_cnt - c0, TO); end
    tests++; if (rsp_err !== 1'b1 || rsp_rdata !== '0 || rsp_id !== 2'd3) begin
      fails++; $display("FAIL to_rsp got=%0b/%0h/%0d exp=1/0/3", rsp_err, rsp_rdata, rsp_id); end
    ready_en = 1'b1;
    tick();
    set_req(0, 1'b0, 8'h23, '0);
    wait_done(d, n);
    req[0] = 1'b0;
    tests++; if (d !== 4'b0001 || n !== 4 || rsp_err !== 1'b0 || rsp_rdata !== 32'hC0DE0003 || rsp_id !== 2'd0) begin
      fails++; $display("FAIL to_recover got=%b/%0d/%0b/%0h/%0d exp=0001/4/0/c0de0003/0", d, n, rsp_err, rsp_rdata, rsp_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] d;
    logic [NREQ+DW+1+IDW+4+AW+DW-1:0] outs;
    int n;
    set_req(1, 1'b1, 8'h34, 32'h34343434);
    wait_done(d, n);
    req[1] = 1'b0;
    tick();
    set_req(1, 1'b1, 8'h38, 32'h38383838);
    set_req(3, 1'b1, 8'h30, 32'h30303030);
    tick();
    tick();
    tests++; if (p_en !== 1'b1 || addr !== 8'h30) begin fails++; $display("FAIL rstmid_access got=%b/%0h exp=1/30", p_en, addr); end
    rst = 1'b1;
    #1;
    outs = {req_done, rsp_rdata, rsp_err, rsp_id, busy, p_sel, p_en, p_write, addr, wdata};
    tests++; if (outs !== '0) begin fails++; $display("FAIL rstmid_outputs got=%0h exp=0", outs); end
    tick();
    rst = 1'b0;
    wait_done(d, n);
    req[1] = 1'b0;
    tests++; if (d !== 4'b0010 || n !== 4) begin fails++; $display("FAIL rstmid_ptr0 got=%b/%0d exp=0010/4", d, n); end
    wait_done(d, n);
    req[3] = 1'b0;
    tests++; if (d !== 4'b1000 || n !== 4 || mem[8'h30] !== 32'h30303030) begin
      fails++; $display("FAIL rstmid_regrant got=%b/%0d/%0h exp=1000/4/30303030", d, n, mem[8'h30]); end
    tick();
  endtask

  task automatic test_unwritten_read();
    logic [NREQ-1:0] d;
    int n;
    apply_reset();
    set_req(2, 1'b0, 8'h77, '0);
    wait_done(d, n);
    req[2] = 1'b0;
    tests++; if (d !== 4'b0100 || n !== 4 || rsp_rdata !== '0 || rsp_err !== 1'b0 || rsp_id !== 2'd2) begin
      fails++; $display("FAIL unwritten got=%b/%0d/%0h/%0b/%0d exp=0100/4/0/0/2", d, n, rsp_rdata, rsp_err, rsp_id); end
    tick();
    tests++; if (viol !== 0) begin fails++; $display("FAIL protocol_order got=%0d exp=0", viol); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_hold_masking();
    test_timeout();
    test_reset_mid();
    test_unwritten_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
